// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package mem_ctrl_pkg;

  localparam int SRAM_DW         = 16;
  localparam int SRAM_AW         = 18;
  localparam int DEF_ADDR_BASE   = 1024;
  localparam int DEF_WAIT_CYCLES = 2;

  // Access sequencer states: one 16-bit phase per half of the 32-bit word.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  // Everything driven onto the SRAM pins, registered as one bundle.
  typedef struct packed {
    logic               we_n;
    logic               oe_n;
    logic               dq_oe;
    logic [SRAM_DW-1:0] dq;
    logic [SRAM_AW-1:0] addr;
  } bus_t;

endpackage

// File: rtl/sram_mem_controller.sv
// MEM-stage controller: splits each 32-bit load/store into two 16-bit
// asynchronous-SRAM phases (low half-word first) and freezes the pipeline
// through ready while the access is in flight.
// Optional build macro ALIGN_CHECK_EN: adds misalign_err and short-circuits
// requests whose address is not word aligned.
module sram_mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_BASE   = DEF_ADDR_BASE,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
`ifdef ALIGN_CHECK_EN
  ,
  output logic               misalign_err
`endif
);

  // Last count value of a phase.
  localparam logic [3:0] TERM = 4'(WAIT_CYCLES - 1);

  localparam bus_t BUS_IDLE = '{we_n: 1'b1, oe_n: 1'b1, dq_oe: 1'b0,
                                dq: {SRAM_DW{1'b0}}, addr: {SRAM_AW{1'b0}}};

  state_e       state_r, state_s;
  logic [3:0]   cnt_r, cnt_s;
  logic         op_wr_r, op_wr_s;
  logic         req_s;
  logic         misalign_s;
  logic [16:0]  word_s;
  logic         lo_cap_s, hi_cap_s;
  logic [31:0]  read_data_r;
  bus_t         bus_r, bus_s;

  // Pin values for a given sequencer position. The dq field always carries
  // the half-word of the current phase; dq_oe alone decides whether it is
  // put on the bus. WE_N is released on the last cycle of each phase so the
  // address and data are still stable when the SRAM latches the write.
  function automatic bus_t drive_decode(input state_e st, input logic [3:0] cnt,
                                        input logic op_wr, input logic [16:0] word,
                                        input logic [31:0] wdata);
    bus_t b;
    b      = BUS_IDLE;
    b.dq   = wdata[15:0];
    case (st)
      LOW: begin
        b.addr = {word, 1'b0};
        if (op_wr) begin
          b.dq_oe = 1'b1;
          b.we_n  = (cnt == TERM);
        end else begin
          b.oe_n = 1'b0;
        end
      end
      HIGH: begin
        b.addr = {word, 1'b1};
        b.dq   = wdata[31:16];
        if (op_wr) begin
          b.dq_oe = 1'b1;
          b.we_n  = (cnt == TERM);
        end else begin
          b.oe_n = 1'b0;
        end
      end
      default: begin
        b.addr = {SRAM_AW{1'b0}};
      end
    endcase
    return b;
  endfunction

  assign req_s  = rd_en | wr_en;
  assign word_s = 17'((address - 32'(ADDR_BASE)) >> 2);

`ifdef ALIGN_CHECK_EN
  assign misalign_s = (address[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif

  // Next state, phase counter and latched access type.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    op_wr_s = op_wr_r;
    case (state_r)
      IDLE: begin
        cnt_s = 4'd0;
        if (req_s) begin
          op_wr_s = wr_en;
          if (misalign_s) begin
            state_s = DONE;
          end else begin
            state_s = LOW;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LOW: begin
        if (!req_s) begin
          state_s = IDLE;
          cnt_s   = 4'd0;
        end else if (cnt_r == TERM) begin
          state_s = HIGH;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      HIGH: begin
        if (!req_s) begin
          state_s = IDLE;
          cnt_s   = 4'd0;
        end else if (cnt_r == TERM) begin
          state_s = DONE;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      DONE: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Read half-words are taken on the terminal edge of their phase.
  always_comb begin
    lo_cap_s = (state_r == LOW)  && req_s && (cnt_r == TERM) && !op_wr_r;
    hi_cap_s = (state_r == HIGH) && req_s && (cnt_r == TERM) && !op_wr_r;
    bus_s    = drive_decode(state_s, cnt_s, op_wr_s, word_s, write_data);
  end

  // Sequencer state, counter and registered SRAM pin bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      op_wr_r <= 1'b0;
      bus_r   <= BUS_IDLE;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      op_wr_r <= op_wr_s;
      bus_r   <= bus_s;
    end
  end

  // Load data register; writes and aborted reads leave captured bits alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data_r <= 32'd0;
    end else begin
      if (lo_cap_s) begin
        read_data_r[15:0] <= SRAM_DQ;
      end
      if (hi_cap_s) begin
        read_data_r[31:16] <= SRAM_DQ;
      end
    end
  end

`ifdef ALIGN_CHECK_EN
  logic misalign_r;

  // Flag is high only in the DONE cycle produced by a misaligned request.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= (state_r == IDLE) && req_s && misalign_s;
    end
  end

  assign misalign_err = misalign_r;
`endif

  assign ready     = ~req_s | (state_r == DONE);
  assign read_data = read_data_r;
  assign SRAM_ADDR = bus_r.addr;
  assign SRAM_WE_N = bus_r.we_n;
  assign SRAM_OE_N = bus_r.oe_n;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_DQ   = bus_r.dq_oe ? bus_r.dq : {SRAM_DW{1'bz}};

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- MEM-stage controller that sequences 32-bit data-memory reads and writes onto a 16-bit external asynchronous SRAM.
- Sits between the EXE/MEM pipeline register (MEM_R_EN, MEM_W_EN, ALU_result as address, ST_Val as write data) and the SRAM pins.
- Drives `ready`; the pipeline uses its inverse as a freeze for every stage register while an access is in flight.

Parameters:
- ADDR_BASE, 1024: byte offset subtracted from the ALU address before SRAM mapping.
- WAIT_CYCLES, 2: cycles per 16-bit SRAM phase; legal range 2..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- rd_en  in  1  read request (MEM_R_EN)
- wr_en  in  1  write request (MEM_W_EN)
- address  in  32  byte address (ALU_result)
- write_data  in  32  store value (ST_Val)
- read_data  out  32  loaded word
- ready  out  1  high = pipeline may advance
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_ADDR  out  18  SRAM half-word address
- SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  SRAM controls, active-low

Behaviour:
- Clocking and reset: one clock (clk). rst is synchronous and active-high.
- Reset values: state IDLE, phase counter 0, read_data 0, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ high-Z. SRAM_CE_N, SRAM_UB_N and SRAM_LB_N are constant 0.
- States: IDLE, LOW, HIGH, DONE.
- IDLE: go to LOW when (rd_en|wr_en); the counter clears to 0.
- LOW: the counter increments each cycle. At count WAIT_CYCLES-1, go to HIGH and clear the counter.
- HIGH: same counting rule as LOW; on terminal count, go to DONE.
- DONE: unconditionally go to IDLE on the next edge.
- Request priority: a write wins. If rd_en and wr_en are both high, the access is a write.
- ready is combinational: ready = ~(rd_en|wr_en) | (state==DONE).
- Latency with W=WAIT_CYCLES:
  - A request first seen in cycle 0 gives ready=0 in cycles 0..2W.
  - ready=1 in cycle 2W+1 (the DONE cycle), during which the pipeline advances.
  - With W=2, ready goes high in cycle 5.
- Address mapping: word = (address - ADDR_BASE) >> 2, truncated to 17 bits, with wrap-around modulo 2^17.
  - LOW phase: SRAM_ADDR = {word,1'b0}.
  - HIGH phase: SRAM_ADDR = {word,1'b1}.
  - IDLE/DONE: SRAM_ADDR = 0.
- Write access:
  - SRAM_DQ drives write_data[15:0] in LOW and write_data[31:16] in HIGH; it is high-Z otherwise.
  - SRAM_WE_N=0 in every phase cycle except the last cycle of each phase, so the address is stable at WE_N rise.
  - SRAM_OE_N=1 throughout.
- Read access:
  - SRAM_OE_N=0 during LOW and HIGH; SRAM_DQ is high-Z.
  - read_data[15:0] is captured on the terminal-count edge of LOW; read_data[31:16] on the terminal-count edge of HIGH.
  - read_data is valid in DONE and holds until the next read completes. A write never alters it.
- Request dropped mid-access (rd_en=wr_en=0 in LOW/HIGH):
  - Return to IDLE on the next edge; no DONE cycle is produced.
  - Bits already captured into read_data remain.
- Request changes mid-access: not permitted. Inputs are required stable while ready=0.
- rst asserted in any state: the reset values apply at that edge. SRAM_WE_N and SRAM_OE_N read 1 from the following cycle.
- Back-to-back accesses: a request held after DONE starts a fresh access from IDLE. The minimum spacing is 2W+2 cycles.

Optional Feature:
- Macro: ALIGN_CHECK_EN.
- Defined:
  - Adds output misalign_err (1 bit, reset 0).
  - A request with address[1:0]!=0 seen in IDLE goes directly to DONE, with no SRAM activity.
  - misalign_err=1 for that DONE cycle only; read_data is unchanged.
- Undefined:
  - Port absent.
  - address[1:0] is ignored and the access proceeds normally.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - the state enum (IDLE/LOW/HIGH/DONE);
  - SRAM_DW=16 and SRAM_AW=18;
  - the default ADDR_BASE and WAIT_CYCLES.
- No sub-module: FSM, counter and bus drivers stay in one module. The tri-state driver is a single continuous assignment.

Test Plan:
- Write then read, W=2:
  - wr_en=1, address=1024+8, write_data=0xDEADBEEF → ready=0 for cycles 0..4, ready=1 in cycle 5.
  - The SRAM model holds 0xBEEF at addr 4 and 0xDEAD at addr 5.
  - Then rd_en=1 at the same address → read_data=0xDEADBEEF in the DONE cycle.
- Idle pass-through: rd_en=wr_en=0 for 10 cycles → ready=1 throughout, WE_N=OE_N=1, DQ high-Z.
- Simultaneous rd_en=wr_en=1, address=1024, write_data=0x12345678 → write performed (SRAM addr 0=0x5678, addr 1=0x1234); read_data unchanged.
- Reset mid-access: assert rst in the second HIGH cycle of a write → next cycle state IDLE, WE_N=1, DQ high-Z; ready=1 once requests drop.
- Address wrap: address=1024+0x80004 → SRAM_ADDR 2 then 3 (17-bit word index wraps to 1).
- ALIGN_CHECK_EN defined: rd_en=1, address=1026 → ready=1 and misalign_err=1 in cycle 1; OE_N stays 1.
